mem_responder: RTL

Single-port, word-organised memory that acts as the responder end of the core's `valid`/`ready` memory interface (`*_valid_o`, `*_ready_i`, `*_addr_o`, `*_wdata_o`, `*_we_o[3:0]`, `*_rdata_i`). One instance attaches to the instruction port and another to the data port in SoC and simulation tops. It inserts a programmable number of wait states, applies byte-lane writes, and flags accesses outside its address window.

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Responder-side memory bus: valid/ready request with byte-lane write enables.
// Signals:
//   mem_valid_i  request present, held with address/data/enables until ready
//   mem_ready_o  one-cycle completion pulse
//   mem_addr_i   byte address (bits [1:0] ignored by the responder)
//   mem_wdata_i  write data
//   mem_we_i     byte-lane write enables, all zero = read
//   mem_rdata_o  read data, held after the completion pulse
//   mem_err_o    out-of-range flag, pulses with mem_ready_o
interface mem_responder_if;
  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam int unsigned RISCV_WORD_WIDTH = 32;

  logic                        mem_valid_i;
  logic                        mem_ready_o;
  logic [RISCV_ADDR_WIDTH-1:0] mem_addr_i;
  logic [RISCV_WORD_WIDTH-1:0] mem_wdata_i;
  logic [3:0]                  mem_we_i;
  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_o;
  logic                        mem_err_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_we_i,
    input  mem_ready_o, mem_rdata_o, mem_err_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_we_i,
    output mem_ready_o, mem_rdata_o, mem_err_o
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory acting as the responder of a valid/ready memory bus.
// Inserts WAIT_CYCLES wait states per access, applies byte-lane writes and
// flags accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    mem_responder_if slave modport (request in, response out)
// Optional feature macro: MEM_RESPONDER_STALL_EN adds 0..3 random extra wait
// states per access from a 16-bit Fibonacci LFSR (taps 16,14,13,11).
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_responder_if.slave   bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned WORD_W = 32;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [29:0]       r_word;
  logic [WORD_W-1:0] r_wdata;
  logic [3:0]        r_we;
  logic              r_ready, w_ready_nxt;
  logic              r_err, w_err_nxt;
  logic [WORD_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_commit;
  logic              w_capture;

  logic [29:0]       w_word;
  logic [WORD_W-1:0] w_wdata;
  logic [3:0]        w_we;
  logic [29:0]       w_rel;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_extra;
  logic [CNT_W-1:0]  w_load;
  logic              w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^bus.mem_addr_i[1:0];

`ifdef MEM_RESPONDER_STALL_EN
  // Free-running LFSR; its low two bits add random wait states at capture.
  logic [15:0] r_lfsr;
  logic        w_fb;
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {w_fb, r_lfsr[15:1]};
  end

  assign w_extra = CNT_W'(r_lfsr[1:0]);
`else
  assign w_extra = '0;
`endif

  assign w_load = CNT_W'(WAIT_CYCLES) + w_extra;

  // With zero wait states the commit happens on the capture edge, so use the live bus.
  assign w_word  = (r_state == S_IDLE) ? bus.mem_addr_i[31:2] : r_word;
  assign w_wdata = (r_state == S_IDLE) ? bus.mem_wdata_i      : r_wdata;
  assign w_we    = (r_state == S_IDLE) ? bus.mem_we_i         : r_we;

  // Word-granular range check; BASE_ADDR is aligned so bits [1:0] never matter.
  assign w_rel      = w_word - BASE_WORD;
  assign w_in_range = (w_word >= BASE_WORD) && (w_rel < DEPTH_W30);
  assign w_idx      = w_rel[IDX_W-1:0];

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = r_rdata;
    w_commit    = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.mem_valid_i) begin
          w_capture = 1'b1;
          if (w_load != '0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_load;
          end else begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mem_valid_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_commit) begin
      w_ready_nxt = 1'b1;
      w_err_nxt   = !w_in_range;
      if (w_we == 4'h0) begin
        w_rdata_nxt = w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  // FSM, request capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_capture) begin
        r_word  <= bus.mem_addr_i[31:2];
        r_wdata <= bus.mem_wdata_i;
        r_we    <= bus.mem_we_i;
      end
    end
  end

  // Storage array: not reset, byte-lane write on entry to RESP.
  always_ff @(posedge clk) begin
    if (w_commit && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign bus.mem_ready_o = r_ready;
  assign bus.mem_err_o   = r_err;
  assign bus.mem_rdata_o = r_rdata;

endmodule
